fb_stage_ctrl: RTL and testbench

Sequencer for the ECG filter-bank (wavelet) decomposition datapath. On a start pulse it runs STAGES analysis stages over an N = 2^LOG_N sample frame held in a ping-pong dual-port BRAM. Each cycle it issues one read-pair address, delays the write addresses to match the datapath latency, and steers outputs: the low band goes back to the other ping-pong bank and the high band goes to the m2 coefficient memory. It owns bank switching, stage selects and drain timing.

---
 rtl/fb_stage_if.sv | 30 +++
 rtl/fb_stage_ctrl.sv | 161 ++++++++++++++++
 tb/tb_fb_stage_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fb_stage_if.sv
// Control bundle between the filter-bank stage sequencer and the datapath/BRAM side.
// The master drives all addresses, enables and status. The slave drives start.
interface fb_stage_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] addra;
  logic [ADDR_W-1:0] addrb;
  logic              rd_en;
  logic              switch;
  logic [ADDR_W-1:0] wb_addr;
  logic              wb_we;
  logic [ADDR_W-1:0] m2_address;
  logic              m2_we;
  logic [2:0]        stage;

  modport master (
    input  start,
    output busy, done, addra, addrb, rd_en, switch,
    output wb_addr, wb_we, m2_address, m2_we, stage
  );

  modport slave (
    output start,
    input  busy, done, addra, addrb, rd_en, switch,
    input  wb_addr, wb_we, m2_address, m2_we, stage
  );
endinterface

// File: rtl/fb_stage_ctrl.sv
// Wavelet filter-bank sequencer: one read pair per RUN cycle; writes follow LAT cycles later.
// There is no backpressure. Each stage drains for LAT cycles before the ping-pong bank flips.
module fb_stage_ctrl #(
  parameter int ADDR_W = 12,
  parameter int LOG_N  = 10,
  parameter int STAGES = 4,
  parameter int LAT    = 3
) (
  input  logic     clk,
  input  logic     rst,
  fb_stage_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic              switch_q, switch_d;
  logic [2:0]        stage_q, stage_d;
  logic [3:0]        drain_q, drain_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] addra_q, addra_d;
  logic [ADDR_W-1:0] addrb_q, addrb_d;

  logic              pipe_vld_q [LAT];
  logic              pipe_vld_d [LAT];
  logic [ADDR_W-1:0] pipe_k_q   [LAT];
  logic [ADDR_W-1:0] pipe_k_d   [LAT];
  logic [ADDR_W-1:0] pipe_m2_q  [LAT];
  logic [ADDR_W-1:0] pipe_m2_d  [LAT];

  logic [ADDR_W-1:0] pairs;
  logic [ADDR_W-1:0] k_last;

  // P_s = N >> (s+1); the stage limit keeps this at 2 or more.
  assign pairs  = ONE << (LOG_N - 1 - int'(stage_q));
  assign k_last = pairs - ONE;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    rd_en_d  = rd_en_q;
    switch_d = switch_q;
    stage_d  = stage_q;
    drain_d  = drain_q;
    k_d      = k_q;
    addra_d  = addra_q;
    addrb_d  = addrb_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          stage_d = 3'd0;
          k_d     = '0;
          addra_d = '0;
          addrb_d = ONE;
        end
      end
      RUN: begin
        if (k_q == k_last) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
          drain_d = 4'(LAT);
          k_d     = '0;
          addra_d = '0;
          addrb_d = '0;
        end else begin
          k_d     = k_q + ONE;
          addra_d = {k_d[ADDR_W-2:0], 1'b0};
          addrb_d = {k_d[ADDR_W-2:0], 1'b1};
        end
      end
      DRAIN: begin
        if (drain_q == 4'd1) begin
          switch_d = ~switch_q;
          if (stage_q == 3'(STAGES - 1)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stage_d = 3'd0;
          end else begin
            state_d = RUN;
            stage_d = stage_q + 3'd1;
            rd_en_d = 1'b1;
            addra_d = '0;
            addrb_d = ONE;
          end
        end else begin
          drain_d = drain_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Idle slots carry zero addresses so the write outputs rest at 0.
  always_comb begin
    pipe_vld_d[0] = rd_en_q;
    pipe_k_d[0]   = rd_en_q ? k_q : '0;
    pipe_m2_d[0]  = rd_en_q ? (pairs + k_q) : '0;
    for (int i = 1; i < LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_k_d[i]   = pipe_k_q[i-1];
      pipe_m2_d[i]  = pipe_m2_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      switch_q <= 1'b0;
      stage_q  <= 3'd0;
      drain_q  <= 4'd0;
      k_q      <= '0;
      addra_q  <= '0;
      addrb_q  <= '0;
      for (int i = 0; i < LAT; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_k_q[i]   <= '0;
        pipe_m2_q[i]  <= '0;
      end
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      rd_en_q  <= rd_en_d;
      switch_q <= switch_d;
      stage_q  <= stage_d;
      drain_q  <= drain_d;
      k_q      <= k_d;
      addra_q  <= addra_d;
      addrb_q  <= addrb_d;
      for (int i = 0; i < LAT; i++) begin
        pipe_vld_q[i] <= pipe_vld_d[i];
        pipe_k_q[i]   <= pipe_k_d[i];
        pipe_m2_q[i]  <= pipe_m2_d[i];
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.switch     = switch_q;
  assign bus.stage      = stage_q;
  assign bus.addra      = addra_q;
  assign bus.addrb      = addrb_q;
  assign bus.wb_we      = pipe_vld_q[LAT-1];
  assign bus.m2_we      = pipe_vld_q[LAT-1];
  assign bus.wb_addr    = pipe_k_q[LAT-1];
  assign bus.m2_address = pipe_m2_q[LAT-1];
endmodule

// File: tb/tb_fb_stage_ctrl.sv
// Directed bench: small config (N=16, 3 stages, LAT=2) table-checked per cycle,
// plus the default config and a single-stage config checked by counters.
module tb_fb_stage_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fb_stage_if #(.ADDR_W(12)) if_a ();
  fb_stage_if #(.ADDR_W(12)) if_b ();
  fb_stage_if #(.ADDR_W(12)) if_c ();

  fb_stage_ctrl #(.ADDR_W(12), .LOG_N(4),  .STAGES(3), .LAT(2)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  fb_stage_ctrl #(.ADDR_W(12), .LOG_N(10), .STAGES(4), .LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  fb_stage_ctrl #(.ADDR_W(12), .LOG_N(4),  .STAGES(1), .LAT(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  typedef struct {
    logic        busy;
    logic        rd_en;
    logic [11:0] addra;
    logic [11:0] addrb;
    logic        wb_we;
    logic [11:0] wb_addr;
    logic        m2_we;
    logic [11:0] m2_addr;
    logic        sw;
    logic [2:0]  stage;
    logic        done;
  } vec_t;

  localparam int ROWS = 21;
  vec_t vec [ROWS];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, row, act, exp);
    end
  endtask

  // Expected per-cycle trace of one frame, cycle 0 = first cycle after start is taken.
  task automatic build_table();
    int c;
    int p;
    c = 0;
    for (int r = 0; r < ROWS; r++) begin
      vec[r].busy = 1'b1;   vec[r].rd_en = 1'b0;
      vec[r].addra = '0;    vec[r].addrb = '0;
      vec[r].wb_we = 1'b0;  vec[r].wb_addr = '0;
      vec[r].m2_we = 1'b0;  vec[r].m2_addr = '0;
      vec[r].sw = 1'b0;     vec[r].stage = '0;
      vec[r].done = 1'b0;
    end
    for (int s = 0; s < 3; s++) begin
      p = 8 >> s;
      for (int r = c; r < c + p + 2; r++) begin
        vec[r].stage = 3'(s);
        vec[r].sw    = 1'((s % 2));
      end
      for (int k = 0; k < p; k++) begin
        vec[c+k].rd_en     = 1'b1;
        vec[c+k].addra     = 12'(2 * k);
        vec[c+k].addrb     = 12'(2 * k + 1);
        vec[c+k+2].wb_we   = 1'b1;
        vec[c+k+2].wb_addr = 12'(k);
        vec[c+k+2].m2_we   = 1'b1;
        vec[c+k+2].m2_addr = 12'(p + k);
      end
      c = c + p + 2;
    end
    vec[20].busy  = 1'b0;
    vec[20].done  = 1'b1;
    vec[20].sw    = 1'b1;
    vec[20].stage = 3'd0;
  endtask

  task automatic check_row(input int r, input logic base);
    check("busy",    r, 32'(if_a.busy),       32'(vec[r].busy));
    check("done",    r, 32'(if_a.done),       32'(vec[r].done));
    check("rd_en",   r, 32'(if_a.rd_en),      32'(vec[r].rd_en));
    check("switch",  r, 32'(if_a.switch),     32'(vec[r].sw ^ base));
    check("stage",   r, 32'(if_a.stage),      32'(vec[r].stage));
    check("wb_we",   r, 32'(if_a.wb_we),      32'(vec[r].wb_we));
    check("m2_we",   r, 32'(if_a.m2_we),      32'(vec[r].m2_we));
    check("wb_addr", r, 32'(if_a.wb_addr),    32'(vec[r].wb_addr));
    check("m2_addr", r, 32'(if_a.m2_address), 32'(vec[r].m2_addr));
    if (vec[r].rd_en) begin
      check("addra", r, 32'(if_a.addra), 32'(vec[r].addra));
      check("addrb", r, 32'(if_a.addrb), 32'(vec[r].addrb));
    end
  endtask

  // Samples are taken 1 time unit after each rising edge.
  task automatic run_table(input bit launch, input bit hold, input logic base);
    if (launch) begin
      if_a.start = 1'b1;
      @(posedge clk); #1;
    end
    for (int r = 0; r < ROWS; r++) begin
      check_row(r, base);
      if_a.start = hold;
      @(posedge clk); #1;
    end
    if_a.start = 1'b0;
  endtask

  int busy_b, done_b, last0_b, last3_b;
  int rd_c, wr_c, busy_c, done_c;

  initial begin
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    build_table();

    #2 rst = 1'b1;
    #1;
    check("rst_busy",  0, 32'(if_a.busy),       0);
    check("rst_done",  0, 32'(if_a.done),       0);
    check("rst_rd_en", 0, 32'(if_a.rd_en),      0);
    check("rst_wb_we", 0, 32'(if_a.wb_we),      0);
    check("rst_m2_we", 0, 32'(if_a.m2_we),      0);
    check("rst_sw",    0, 32'(if_a.switch),     0);
    check("rst_stage", 0, 32'(if_a.stage),      0);
    check("rst_addra", 0, 32'(if_a.addra),      0);
    check("rst_addrb", 0, 32'(if_a.addrb),      0);
    check("rst_m2",    0, 32'(if_a.m2_address), 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1 with start held high throughout; the start seen in the done
    // cycle launches frame 2 reading from bank 1.
    run_table(1'b1, 1'b1, 1'b0);
    run_table(1'b0, 1'b0, 1'b1);
    check("idle_busy", 21, 32'(if_a.busy),   0);
    check("idle_done", 21, 32'(if_a.done),   0);
    check("idle_sw",   21, 32'(if_a.switch), 0);
    check("idle_rd",   21, 32'(if_a.rd_en),  0);

    // Frame 3: reset in the middle of stage 1 while writes are active.
    if_a.start = 1'b1;
    @(posedge clk); #1;
    if_a.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("pre_rst_stage", 12, 32'(if_a.stage),  1);
    check("pre_rst_sw",    12, 32'(if_a.switch), 1);
    check("pre_rst_wb_we", 12, 32'(if_a.wb_we),  1);
    #1 rst = 1'b1;
    #1;
    check("arst_rd_en", 12, 32'(if_a.rd_en),  0);
    check("arst_wb_we", 12, 32'(if_a.wb_we),  0);
    check("arst_m2_we", 12, 32'(if_a.m2_we),  0);
    check("arst_busy",  12, 32'(if_a.busy),   0);
    check("arst_sw",    12, 32'(if_a.switch), 0);
    check("arst_stage", 12, 32'(if_a.stage),  0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("arst_no_done", 13 + i, 32'(if_a.done), 0);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    run_table(1'b1, 1'b0, 1'b0);
    check("final_sw",   21, 32'(if_a.switch), 1);
    check("final_busy", 21, 32'(if_a.busy),   0);

    // Default and single-stage configurations, run side by side.
    busy_b = 0; done_b = 0; last0_b = -1; last3_b = -1;
    rd_c = 0; wr_c = 0; busy_c = 0; done_c = 0;
    if_b.start = 1'b1;
    if_c.start = 1'b1;
    @(posedge clk); #1;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    for (int cyc = 0; cyc < 1100; cyc++) begin
      if (if_b.busy) busy_b++;
      if (if_b.done) done_b++;
      if (if_b.m2_we && if_b.stage == 3'd0) last0_b = int'(if_b.m2_address);
      if (if_b.m2_we && if_b.stage == 3'd3) last3_b = int'(if_b.m2_address);
      if (if_c.busy)  busy_c++;
      if (if_c.done)  done_c++;
      if (if_c.rd_en) rd_c++;
      if (if_c.wb_we) begin
        check("c_wb_addr", cyc, 32'(if_c.wb_addr),    32'(wr_c));
        check("c_m2_addr", cyc, 32'(if_c.m2_address), 32'(8 + wr_c));
        check("c_m2_we",   cyc, 32'(if_c.m2_we),      1);
        wr_c++;
      end
      @(posedge clk); #1;
    end
    check("b_busy_cycles", 0, 32'(busy_b),  972);
    check("b_done_count",  0, 32'(done_b),  1);
    check("b_last_m2_s0",  0, 32'(last0_b), 1023);
    check("b_last_m2_s3",  0, 32'(last3_b), 127);
    check("c_reads",       0, 32'(rd_c),    8);
    check("c_writes",      0, 32'(wr_c),    8);
    check("c_busy_cycles", 0, 32'(busy_c),  9);
    check("c_done_count",  0, 32'(done_c),  1);
    check("c_final_sw",    0, 32'(if_c.switch), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
